stopwatch_counter: RTL and testbench

Time-base and BCD counting datapath driven by the stopwatch control FSM. It consumes the FSM's `en` (run) and `rst` (clear) outputs. It divides `clk` down to a centisecond tick and accumulates elapsed time as minutes:seconds.centiseconds in BCD. It also provides a lap-hold display freeze for the downstream seven-segment driver.

---
 rtl/stopwatch_counter.sv | 122 ++++++++++++
 tb/tb_stopwatch_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Divides clk down to a centisecond tick and accumulates elapsed time as
//   mm:ss.cc in BCD. It also provides a lap hold that freezes the display
//   while the live count keeps running.
//
// Parameters
//   CLK_DIV    clk cycles per centisecond (>= 2)
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset; clears every register
//   en         run enable (level)
//   rst        synchronous clear (level); overrides en and lap
//   lap        single-cycle pulse; toggles the lap hold
//   disp_cs    displayed centiseconds, BCD {tens, ones}
//   disp_sec   displayed seconds, BCD
//   disp_min   displayed minutes, BCD
//   lap_active lap hold in effect (display shows the shadow copy)
//   rollover   one-cycle pulse after 59:59.99 wraps to 00:00.00
module stopwatch_counter #(
  parameter int CLK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rst,
  input  logic       lap,
  output logic [7:0] disp_cs,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       lap_active,
  output logic       rollover
);

  localparam int              PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre;
  logic [7:0]    cs, sec, min;
  logic [7:0]    sh_cs, sh_sec, sh_min;

  // Two-digit BCD increment that wraps at {top_tens, 9}.
  // Returns {carry_out, next_value}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                         input logic [3:0] top_tens);
    if (v[3:0] != 4'd9)
      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != top_tens)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b1, 8'h00};
  endfunction

  logic       tick;
  logic [8:0] cs_inc, sec_inc, min_inc;
  logic [7:0] sec_nxt, min_nxt;
  logic       wrap;

  // Full ripple cs -> sec -> min within one edge.
  always_comb begin
    tick    = en && (pre == PRE_MAX);
    cs_inc  = bcd_inc(cs, 4'd9);
    sec_inc = bcd_inc(sec, 4'd5);
    min_inc = bcd_inc(min, 4'd5);
    sec_nxt = cs_inc[8] ? sec_inc[7:0] : sec;
    min_nxt = (cs_inc[8] && sec_inc[8]) ? min_inc[7:0] : min;
    wrap    = cs_inc[8] && sec_inc[8] && min_inc[8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      cs         <= '0;
      sec        <= '0;
      min        <= '0;
      sh_cs      <= '0;
      sh_sec     <= '0;
      sh_min     <= '0;
      lap_active <= 1'b0;
      rollover   <= 1'b0;
    end else if (rst) begin
      // Shadows are left alone: they are invisible while lap_active is 0
      // and get recaptured on the next lap.
      pre        <= '0;
      cs         <= '0;
      sec        <= '0;
      min        <= '0;
      lap_active <= 1'b0;
      rollover   <= 1'b0;
    end else begin
      rollover <= tick && wrap;

      // With en low pre simply holds, so a pause at PRE_MAX ticks on the
      // first enabled edge after resume.
      if (tick) begin
        pre <= '0;
        cs  <= cs_inc[7:0];
        sec <= sec_nxt;
        min <= min_nxt;
      end else if (en) begin
        pre <= pre + PW'(1);
      end

      // The shadow samples the pre-edge live value, so a lap landing on a
      // tick edge captures the time before the increment.
      if (lap) begin
        if (!lap_active) begin
          sh_cs      <= cs;
          sh_sec     <= sec;
          sh_min     <= min;
          lap_active <= 1'b1;
        end else begin
          lap_active <= 1'b0;
        end
      end
    end
  end

  assign disp_cs  = lap_active ? sh_cs  : cs;
  assign disp_sec = lap_active ? sh_sec : sec;
  assign disp_min = lap_active ? sh_min : min;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_DIV=4 (one centisecond per
// four enabled edges). Inputs are driven and outputs sampled 1 time unit
// after a rising edge. The 59:59.99 preload is done with force/release on
// the live registers, because counting there would take 1.44M cycles.
module tb_stopwatch_counter;

  logic       clk, reset, en, rst, lap;
  logic [7:0] disp_cs, disp_sec, disp_min;
  logic       lap_active, rollover;
  logic       clk_run;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_counter #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rst        (rst),
    .lap        (lap),
    .disp_cs    (disp_cs),
    .disp_sec   (disp_sec),
    .disp_min   (disp_min),
    .lap_active (lap_active),
    .rollover   (rollover)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] disp();
    return {8'h00, disp_min, disp_sec, disp_cs};
  endfunction

  // Synchronous clear lasting one edge.
  task automatic clear();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Deposit 59:59.99 into the live registers (pre is 0 after a clear).
  task automatic preload_max();
    force dut.cs  = 8'h99;
    force dut.sec = 8'h59;
    force dut.min = 8'h59;
    #1;
    release dut.cs;
    release dut.sec;
    release dut.min;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk_run = 1'b1;
    reset = 1'b1; en = 1'b0; rst = 1'b0; lap = 1'b0;
    #1;
    chk("reset_disp", disp(), 32'h000000);
    chk("reset_lap",  {31'd0, lap_active}, 32'd0);
    chk("reset_roll", {31'd0, rollover},   32'd0);
    step(2);
    reset = 1'b0;

    // Async reset mid-count with lap hold active and the clock stopped.
    en = 1'b1;
    step(12);
    chk("pre_areset_disp", disp(), 32'h000003);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("pre_areset_lap", {31'd0, lap_active}, 32'd1);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_disp", disp(), 32'h000000);
    chk("areset_lap",  {31'd0, lap_active}, 32'd0);
    #20;
    reset = 1'b0;
    clk_run = 1'b1;
    en = 1'b0;
    step(1);

    // Counting and BCD carries.
    clear();
    en = 1'b1;
    step(36);
    chk("count_09", disp(), 32'h000009);
    step(4);
    chk("count_10", disp(), 32'h000010);
    step(360);
    chk("count_1s", disp(), 32'h000100);

    // Pause keeps the sub-centisecond fraction.
    clear();
    step(6);
    chk("pause_before", disp(), 32'h000001);
    en = 1'b0;
    step(20);
    chk("pause_hold", disp(), 32'h000001);
    en = 1'b1;
    step(1);
    chk("resume_1", disp(), 32'h000001);
    step(1);
    chk("resume_2", disp(), 32'h000002);

    // en dropped with pre at CLK_DIV-1: tick on the first enabled edge.
    clear();
    step(3);
    en = 1'b0;
    step(5);
    chk("pause_at_max", disp(), 32'h000000);
    en = 1'b1;
    step(1);
    chk("tick_on_resume", disp(), 32'h000001);

    // First tick exactly CLK_DIV edges after clear; rst on a tick edge.
    clear();
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst_on_tick", disp(), 32'h000000);
    rst = 1'b0;
    step(3);
    chk("first_tick_3", disp(), 32'h000000);
    step(1);
    chk("first_tick_4", disp(), 32'h000001);

    // Wrap from 59:59.99.
    en = 1'b0;
    clear();
    preload_max();
    chk("preload", disp(), 32'h595999);
    en = 1'b1;
    step(3);
    chk("wrap_pre_disp", disp(), 32'h595999);
    chk("wrap_pre_roll", {31'd0, rollover}, 32'd0);
    step(1);
    chk("wrap_disp", disp(), 32'h000000);
    chk("wrap_roll", {31'd0, rollover}, 32'd1);
    step(1);
    chk("wrap_roll_off", {31'd0, rollover}, 32'd0);

    // rst on a wrap edge: no increment, no rollover.
    en = 1'b0;
    clear();
    preload_max();
    en = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_wrap_disp", disp(), 32'h000000);
    chk("rst_wrap_roll", {31'd0, rollover}, 32'd0);

    // Lap hold while counting continues.
    clear();
    step(20);
    chk("lap_pre", disp(), 32'h000005);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap_on", {31'd0, lap_active}, 32'd1);
    step(59);
    chk("lap_frozen", disp(), 32'h000005);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap_off", {31'd0, lap_active}, 32'd0);
    chk("lap_live", disp(), 32'h000020);

    // rst together with lap while the hold is active.
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap_again", {31'd0, lap_active}, 32'd1);
    rst = 1'b1; lap = 1'b1;
    step(1);
    rst = 1'b0; lap = 1'b0;
    chk("rst_lap_disp", disp(), 32'h000000);
    chk("rst_lap_act",  {31'd0, lap_active}, 32'd0);

    // lap on the tick edge at 00:00.07 captures the pre-increment value.
    step(31);
    chk("tick_lap_pre", disp(), 32'h000007);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("tick_lap_shadow", disp(), 32'h000007);
    chk("tick_lap_act", {31'd0, lap_active}, 32'd1);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("tick_lap_live", disp(), 32'h000008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
